// File: rtl/uart_response_encoder.sv
// Hex-ASCII response framer and 8N1 UART transmitter: ':' cmd{2} data{2}* ';' [CR LF].
// Optional trailer: define UART_RESPONSE_CRLF_EN to append CR LF after ';'.
module uart_response_encoder #(
  parameter int unsigned CLOCK_FREQ = 12000000,
  parameter int unsigned BOUD_RATE  = 115200
) (
  input  logic       i_master_clk,
  input  logic       i_reset,
  input  logic [7:0] i_cmd,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  input  logic       i_end,
  output logic       o_ready,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_response_sent
);

  localparam int unsigned BIT_CYCLES = CLOCK_FREQ / BOUD_RATE;
  localparam int unsigned BAUD_W     = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START     = 4'd1;
  localparam logic [3:0] S_CMD_HI    = 4'd2;
  localparam logic [3:0] S_CMD_LO    = 4'd3;
  localparam logic [3:0] S_DATA_WAIT = 4'd4;
  localparam logic [3:0] S_DATA_HI   = 4'd5;
  localparam logic [3:0] S_DATA_LO   = 4'd6;
  localparam logic [3:0] S_END       = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
`ifdef UART_RESPONSE_CRLF_EN
  localparam logic [3:0] S_CR        = 4'd9;
  localparam logic [3:0] S_LF        = 4'd10;
`endif

  logic [3:0]        state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        data_q, data_d;
  logic              load;
  logic [7:0]        char_d;
  logic [7:0]        tx_char_q;
  logic [3:0]        bit_q;
  logic [BAUD_W-1:0] baud_q;
  logic              active_q;
  logic              tx_q;
  logic              char_done;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign char_done = active_q && (baud_q == BAUD_LAST) && (bit_q == 4'd9);

  // Each send state loads its successor's char on the finishing edge, so
  // consecutive chars run back-to-back with no idle bit between them.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    load    = 1'b0;
    char_d  = '0;
    case (state_q)
      S_IDLE: if (i_cmd_valid) begin
        state_d = S_START; cmd_d = i_cmd; load = 1'b1; char_d = 8'h3A;
      end
      S_START: if (char_done) begin
        state_d = S_CMD_HI; load = 1'b1; char_d = hex_ascii(cmd_q[7:4]);
      end
      S_CMD_HI: if (char_done) begin
        state_d = S_CMD_LO; load = 1'b1; char_d = hex_ascii(cmd_q[3:0]);
      end
      S_CMD_LO:  if (char_done) state_d = S_DATA_WAIT;
      S_DATA_WAIT: begin
        if (i_end) begin
          state_d = S_END; load = 1'b1; char_d = 8'h3B;
        end else if (i_data_valid) begin
          state_d = S_DATA_HI; data_d = i_data; load = 1'b1; char_d = hex_ascii(i_data[7:4]);
        end
      end
      S_DATA_HI: if (char_done) begin
        state_d = S_DATA_LO; load = 1'b1; char_d = hex_ascii(data_q[3:0]);
      end
      S_DATA_LO: if (char_done) state_d = S_DATA_WAIT;
`ifdef UART_RESPONSE_CRLF_EN
      S_END: if (char_done) begin
        state_d = S_CR; load = 1'b1; char_d = 8'h0D;
      end
      S_CR: if (char_done) begin
        state_d = S_LF; load = 1'b1; char_d = 8'h0A;
      end
      S_LF: if (char_done) state_d = S_DONE;
`else
      S_END: if (char_done) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
    end
  end

  // bit_q: 0 start, 1..8 data LSB first, 9 stop.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      tx_q      <= 1'b1;
      tx_char_q <= '0;
      bit_q     <= '0;
      baud_q    <= '0;
      active_q  <= 1'b0;
    end else if (load) begin
      tx_q      <= 1'b0;
      tx_char_q <= char_d;
      bit_q     <= '0;
      baud_q    <= '0;
      active_q  <= 1'b1;
    end else if (active_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q <= bit_q + 4'd1;
          tx_q  <= (bit_q == 4'd8) ? 1'b1 : tx_char_q[bit_q[2:0]];
        end
      end else begin
        baud_q <= baud_q + 1'b1;
      end
    end
  end

  assign o_uart_tx       = tx_q;
  assign o_ready         = (state_q == S_IDLE) || (state_q == S_DATA_WAIT);
  assign o_busy          = (state_q != S_IDLE);
  assign o_response_sent = (state_q == S_DONE);

endmodule

// File: tb/tb_uart_response_encoder.sv
// Directed self-checking bench for uart_response_encoder at default 12 MHz / 115200 baud.
module tb_uart_response_encoder;

  localparam int BIT  = 104;
  localparam int CHAR = 10 * BIT;
`ifdef UART_RESPONSE_CRLF_EN
  localparam int N_TAIL = 3;
`else
  localparam int N_TAIL = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_cmd = '0;
  logic       i_cmd_valid = 1'b0;
  logic [7:0] i_data = '0;
  logic       i_data_valid = 1'b0;
  logic       i_end = 1'b0;
  logic       o_ready, o_uart_tx, o_busy, o_response_sent;

  uart_response_encoder #(.CLOCK_FREQ(12000000), .BOUD_RATE(115200)) dut (
    .i_master_clk    (clk),
    .i_reset         (rst),
    .i_cmd           (i_cmd),
    .i_cmd_valid     (i_cmd_valid),
    .i_data          (i_data),
    .i_data_valid    (i_data_valid),
    .i_end           (i_end),
    .o_ready         (o_ready),
    .o_uart_tx       (o_uart_tx),
    .o_busy          (o_busy),
    .o_response_sent (o_response_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line receiver: samples mid-bit, drops chars cut by reset.
  logic [7:0] rxq[$];
  int         rxt[$];
  int         ferr = 0;

  task automatic mon_wait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  initial begin : rx_monitor
    logic [7:0] c;
    bit ab;
    int t0;
    forever begin
      @(negedge clk);
      if (!rst && o_uart_tx === 1'b0) begin
        t0 = cyc;
        ab = 1'b0;
        mon_wait(BIT / 2, ab);
        if (!ab && o_uart_tx === 1'b0) begin
          for (int b = 0; b < 8; b++) begin
            mon_wait(BIT, ab);
            c[b] = o_uart_tx;
          end
          mon_wait(BIT, ab);
          if (!ab) begin
            if (o_uart_tx !== 1'b1) ferr++;
            rxq.push_back(c);
            rxt.push_back(t0);
          end
        end
      end
    end
  end

  int pulses = 0, pulse_hi = 0, pulse_t = 0;
  initial begin : pulse_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_response_sent === 1'b1) begin
        pulse_hi++;
        if (!prev) begin
          pulses++;
          pulse_t = cyc;
        end
      end
      prev = (o_response_sent === 1'b1);
    end
  end

  int cmd_t, end_t;
  logic [7:0] exp_q[$];

  task automatic wait_ready(input string tag);
    int i;
    i = 0;
    while (o_ready !== 1'b1 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_ready"}, o_ready, 1'b1);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    wait_ready("cmd");
    i_cmd = c; i_cmd_valid = 1'b1;
    @(negedge clk);
    cmd_t = cyc;
    i_cmd_valid = 1'b0; i_cmd = ~c;
  endtask

  task automatic send_data(input logic [7:0] d);
    wait_ready("data");
    i_data = d; i_data_valid = 1'b1;
    @(negedge clk);
    i_data_valid = 1'b0; i_data = ~d;
  endtask

  task automatic send_end();
    wait_ready("end");
    i_end = 1'b1;
    @(negedge clk);
    end_t = cyc;
    i_end = 1'b0;
  endtask

  task automatic wait_pulse(input string tag);
    int p0, h0, i;
    p0 = pulses; h0 = pulse_hi; i = 0;
    while (pulses == p0 && i < 20000) begin
      @(negedge clk);
      i++;
    end
    repeat (5) @(negedge clk);
    check({tag, "_pulses"}, pulses - p0, 1);
    check({tag, "_pulse_width"}, pulse_hi - h0, 1);
    check({tag, "_pulse_time"}, pulse_t - end_t, N_TAIL * CHAR);
    check({tag, "_idle_ready"}, {o_ready, o_busy, o_uart_tx}, 3'b101);
  endtask

  task automatic expect_str(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef UART_RESPONSE_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_nchars"}, rxq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rxq.size(); i++)
      check($sformatf("%s_char%0d", tag, i), rxq[i], exp_q[i]);
    check({tag, "_framing"}, ferr, 0);
    if (rxt.size() >= 3) begin
      check({tag, "_first_latency"}, rxt[0] - cmd_t, 0);
      check({tag, "_no_gap"}, rxt[2] - rxt[0], 2 * CHAR);
    end
    rxq.delete();
    rxt.delete();
    ferr = 0;
  endtask

  initial begin : watchdog
    #(10 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin : stim
    int bad_tx, bad_rdy, bad_busy, bad_rs, p0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_rs = 0;
    repeat (2000) begin
      @(negedge clk);
      if (o_uart_tx !== 1'b1) bad_tx++;
      if (o_ready !== 1'b1) bad_rdy++;
      if (o_busy !== 1'b0) bad_busy++;
      if (o_response_sent !== 1'b0) bad_rs++;
    end
    check("idle_tx", bad_tx, 0);
    check("idle_ready", bad_rdy, 0);
    check("idle_busy", bad_busy, 0);
    check("idle_pulse", bad_rs, 0);

    // 2: ":3AF007;"
    send_cmd(8'h3A);
    check("t2_accept_state", {o_ready, o_busy, o_uart_tx}, 3'b010);
    send_data(8'hF0);
    send_data(8'h07);
    send_end();
    wait_pulse("t2");
    expect_str(":3AF007;");
    check("t2_colon_hex", exp_q[0], 8'h3A);
    check_frame("t2");

    // 3: zero-payload ":C5;"
    send_cmd(8'hC5);
    send_end();
    wait_pulse("t3");
    expect_str(":C5;");
    check_frame("t3");

    // 4: illegal requests ignored
    i_data = 8'h99; i_data_valid = 1'b1; i_end = 1'b1;
    repeat (5) @(negedge clk);
    i_data_valid = 1'b0; i_end = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_idle_busy", o_busy, 1'b0);
    check("t4_idle_tx", o_uart_tx, 1'b1);
    send_cmd(8'h12);
    wait_ready("t4_dw");
    i_cmd = 8'h34; i_cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    i_cmd_valid = 1'b0;
    check("t4_dw_ready", {o_ready, o_busy}, 2'b11);
    send_end();
    wait_pulse("t4");
    expect_str(":12;");
    check_frame("t4");

    // 5: end and data together -> end wins
    send_cmd(8'h9E);
    wait_ready("t5_dw");
    i_end = 1'b1; i_data = 8'h55; i_data_valid = 1'b1;
    @(negedge clk);
    end_t = cyc;
    i_end = 1'b0; i_data_valid = 1'b0;
    wait_pulse("t5");
    expect_str(":9E;");
    check_frame("t5");

    // 6: reset in data bit 4 of 'A'
    send_cmd(8'hA1);
    repeat (CHAR + 5 * BIT + BIT / 2 - 1) @(negedge clk);
    check("t6_pre_reset_bit", o_uart_tx, 1'b0);
    p0 = pulses;
    rst = 1'b1;
    #1;
    check("t6_reset_outputs", {o_uart_tx, o_ready, o_busy, o_response_sent}, 4'b1100);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    check("t6_no_pulse", pulses - p0, 0);
    check("t6_aborted_chars", rxq.size(), 1);
    check("t6_idle_busy", o_busy, 1'b0);
    rxq.delete(); rxt.delete(); ferr = 0;
    send_cmd(8'h01);
    send_end();
    wait_pulse("t6");
    expect_str(":01;");
    check_frame("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
